dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_if.sv | 45 ++++
 rtl/dispatch_queue.sv | 124 ++++++++++++
 tb/tb_dispatch_queue.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_if.sv
// Handshake/payload bundle between the decode stage, dispatch_queue and the execution units.
// Signal suffixes are from the queue's point of view: the slave modport is the queue itself.
interface dispatch_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_inst_i;
    logic [31:0]      in_pc_i;
    logic             in_alu_i;
    logic             in_lsu_i;
    logic             in_muldiv_i;
    logic             in_br_i;
    logic             alu_valid_o;
    logic             alu_ready_i;
    logic             lsu_valid_o;
    logic             lsu_ready_i;
    logic             muldiv_valid_o;
    logic             muldiv_ready_i;
    logic [31:0]      out_inst_o;
    logic [31:0]      out_pc_o;
    logic             illegal_o;
    logic [OCC_W-1:0] count_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, in_inst_i, in_pc_i,
               in_alu_i, in_lsu_i, in_muldiv_i, in_br_i,
               alu_ready_i, lsu_ready_i, muldiv_ready_i,
        output in_ready_o, alu_valid_o, lsu_valid_o, muldiv_valid_o,
               out_inst_o, out_pc_o, illegal_o, count_o, stall_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, in_inst_i, in_pc_i,
               in_alu_i, in_lsu_i, in_muldiv_i, in_br_i,
               alu_ready_i, lsu_ready_i, muldiv_ready_i,
        input  in_ready_o, alu_valid_o, lsu_valid_o, muldiv_valid_o,
               out_inst_o, out_pc_o, illegal_o, count_o, stall_cnt_o
    );
endinterface

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: circular buffer routing decoded instructions to ALU/LSU/MULDIV.
// Optional empty-queue same-cycle bypass is enabled by defining DISPATCH_BYPASS_EN.
module dispatch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    dispatch_if.slave dq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_LSU     = 2'd1,
        CLS_MULDIV  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } cls_e;

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    cls_e             cls_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    cls_e in_cls_c, head_cls_c, sel_cls_c;
    logic head_valid_c, byp_c, sel_active_c, sel_ready_c;
    logic illegal_c, deq_c, byp_take_c, in_ready_c, enq_c;

    // Branches share the ALU class; anything other than exactly one class is illegal.
    always_comb begin
        in_cls_c = CLS_ILLEGAL;
        case ({dq.in_alu_i | dq.in_br_i, dq.in_lsu_i, dq.in_muldiv_i})
            3'b100:  in_cls_c = CLS_ALU;
            3'b010:  in_cls_c = CLS_LSU;
            3'b001:  in_cls_c = CLS_MULDIV;
            default: in_cls_c = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        head_valid_c = (count_q != '0);
        head_cls_c   = cls_q[head_q];
`ifdef DISPATCH_BYPASS_EN
        byp_c = !head_valid_c && dq.in_valid_i && !dq.flush_i && (in_cls_c != CLS_ILLEGAL);
`else
        byp_c = 1'b0;
`endif
        sel_cls_c    = byp_c ? in_cls_c : head_cls_c;
        sel_active_c = byp_c || (head_valid_c && (head_cls_c != CLS_ILLEGAL));

        sel_ready_c = 1'b0;
        case (sel_cls_c)
            CLS_ALU:    sel_ready_c = dq.alu_ready_i;
            CLS_LSU:    sel_ready_c = dq.lsu_ready_i;
            CLS_MULDIV: sel_ready_c = dq.muldiv_ready_i;
            default:    sel_ready_c = 1'b0;
        endcase

        illegal_c  = head_valid_c && (head_cls_c == CLS_ILLEGAL);
        deq_c      = head_valid_c && (illegal_c || sel_ready_c);
        byp_take_c = byp_c && sel_ready_c;
        in_ready_c = (count_q < OCC_W'(DEPTH));
        enq_c      = dq.in_valid_i && in_ready_c && !dq.flush_i && !byp_take_c;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;

        // Stall counting survives flush; only reset clears it.
        if (head_valid_c && !illegal_c && !sel_ready_c && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (dq.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_c) tail_d = tail_q + PTR_W'(1);
            if (deq_c) head_d = head_q + PTR_W'(1);
            count_d = count_q + OCC_W'(enq_c) - OCC_W'(deq_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Payload storage carries no reset; entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (enq_c) begin
            inst_q[tail_q] <= dq.in_inst_i;
            pc_q[tail_q]   <= dq.in_pc_i;
            cls_q[tail_q]  <= in_cls_c;
        end
    end

    assign dq.in_ready_o     = in_ready_c;
    assign dq.alu_valid_o    = sel_active_c && (sel_cls_c == CLS_ALU);
    assign dq.lsu_valid_o    = sel_active_c && (sel_cls_c == CLS_LSU);
    assign dq.muldiv_valid_o = sel_active_c && (sel_cls_c == CLS_MULDIV);
    assign dq.out_inst_o     = byp_c ? dq.in_inst_i : inst_q[head_q];
    assign dq.out_pc_o       = byp_c ? dq.in_pc_i : pc_q[head_q];
    assign dq.illegal_o      = illegal_c;
    assign dq.count_o        = count_q;
    assign dq.stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed vector table, corner sequences, random vs queue model.
module tb_dispatch_queue;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 6;
    localparam int STALL_MAX = (1 << CNT_W) - 1;
`ifdef DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Class bit patterns {alu,lsu,muldiv,br}; ready patterns {alu,lsu,muldiv}
    localparam logic [3:0] C_ALU  = 4'b1000;
    localparam logic [3:0] C_LSU  = 4'b0100;
    localparam logic [3:0] C_MD   = 4'b0010;
    localparam logic [3:0] C_BR   = 4'b0001;
    localparam logic [3:0] C_NONE = 4'b0000;

    typedef struct {
        logic v, alu, lsu, md, br, flush, ar, lr, mr;
        logic [31:0] inst, pc;
    } in_t;

    typedef struct {
        int cls;
        logic [31:0] inst, pc;
    } ent_t;

    typedef struct {
        in_t in;
        logic [2:0] ev;
        logic eill;
        int ecnt;
        int estall;
        logic [31:0] epc;
    } vec_t;

    logic clk;
    logic rst_n;
    int checks   = 0;
    int failures = 0;

    ent_t mq[$];
    int   m_stall;
    vec_t tbl[9];

    dispatch_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dq ();

    dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .dq     (dq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(logic v, logic [3:0] cb, logic [31:0] pc, logic [2:0] rdy, logic f);
        in_t x;
        x.v = v;  x.alu = cb[3]; x.lsu = cb[2]; x.md = cb[1]; x.br = cb[0];
        x.ar = rdy[2]; x.lr = rdy[1]; x.mr = rdy[0];
        x.flush = f; x.pc = pc; x.inst = pc ^ 32'h5A5A_0000;
        return x;
    endfunction

    // Class 0=ALU 1=LSU 2=MULDIV 3=ILLEGAL: legal only when exactly one resource group is requested
    function automatic int cls_of(in_t x);
        int n = 0;
        int c = 3;
        if (x.alu || x.br) begin n++; c = 0; end
        if (x.lsu)         begin n++; c = 1; end
        if (x.md)          begin n++; c = 2; end
        return (n == 1) ? c : 3;
    endfunction

    function automatic logic rdy_of(in_t x, int c);
        case (c)
            0:       return x.ar;
            1:       return x.lr;
            2:       return x.mr;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] rnd_cls();
        case ($urandom_range(0, 9))
            0, 1, 2: return C_ALU;
            3:       return C_BR;
            4, 5:    return C_LSU;
            6, 7:    return C_MD;
            8:       return C_NONE;
            default: return 4'b0110;
        endcase
    endfunction

    // Drive one cycle of inputs and compare every output against the model
    task automatic drive_check(input in_t x);
        logic [2:0] ev;
        logic eill;
        logic [31:0] epc, einst;
        int ic;
        dq.in_valid_i = x.v;   dq.in_alu_i = x.alu; dq.in_lsu_i = x.lsu;
        dq.in_muldiv_i = x.md; dq.in_br_i = x.br;   dq.flush_i = x.flush;
        dq.alu_ready_i = x.ar; dq.lsu_ready_i = x.lr; dq.muldiv_ready_i = x.mr;
        dq.in_inst_i = x.inst; dq.in_pc_i = x.pc;
        #1;
        ev = '0; eill = 1'b0; epc = '0; einst = '0;
        ic = cls_of(x);
        if (mq.size() > 0) begin
            if (mq[0].cls == 3) eill = 1'b1;
            else ev[mq[0].cls] = 1'b1;
            epc = mq[0].pc; einst = mq[0].inst;
        end else if (BYP && x.v && !x.flush && ic != 3) begin
            ev[ic] = 1'b1; epc = x.pc; einst = x.inst;
        end
        chk("alu_valid",    32'(dq.alu_valid_o),    32'(ev[0]));
        chk("lsu_valid",    32'(dq.lsu_valid_o),    32'(ev[1]));
        chk("muldiv_valid", 32'(dq.muldiv_valid_o), 32'(ev[2]));
        chk("illegal",      32'(dq.illegal_o),      32'(eill));
        chk("count",        32'(dq.count_o),        32'(mq.size()));
        chk("in_ready",     32'(dq.in_ready_o),     32'(mq.size() < DEPTH));
        chk("stall_cnt",    32'(dq.stall_cnt_o),    32'(m_stall));
        if (ev != 3'b000 || eill) begin
            chk("out_pc",   dq.out_pc_o,   epc);
            chk("out_inst", dq.out_inst_o, einst);
        end
    endtask

    // Clock edge plus model update from the same inputs
    task automatic advance(input in_t x);
        int ic, hc;
        bit deq, take, enq;
        ic = cls_of(x);
        hc = 0; deq = 0;
        if (mq.size() > 0) begin
            hc  = mq[0].cls;
            deq = (hc == 3) || rdy_of(x, hc);
            if (hc != 3 && !rdy_of(x, hc) && m_stall < STALL_MAX) m_stall++;
        end
        take = BYP && mq.size() == 0 && x.v && !x.flush && ic != 3 && rdy_of(x, ic);
        enq  = x.v && mq.size() < DEPTH && !x.flush && !take;
        @(posedge clk);
        if (x.flush) mq.delete();
        else begin
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back('{ic, x.inst, x.pc});
        end
        @(negedge clk);
    endtask

    task automatic cycle(input in_t x);
        drive_check(x);
        advance(x);
    endtask

    task automatic do_reset();
        in_t idle;
        idle = mk(1'b0, C_NONE, 32'h0, 3'b000, 1'b0);
        drive_check(idle);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_stall = 0;
        #1;
        chk("rst_count",    32'(dq.count_o),     32'd0);
        chk("rst_in_ready", 32'(dq.in_ready_o),  32'd1);
        chk("rst_stall",    32'(dq.stall_cnt_o), 32'd0);
        chk("rst_valids",   32'({dq.alu_valid_o, dq.lsu_valid_o, dq.muldiv_valid_o}), 32'd0);
        chk("rst_illegal",  32'(dq.illegal_o),   32'd0);
    endtask

    initial begin
        in_t x, x5, idle_r, idle_a;
        rst_n = 1'b0;
        m_stall = 0;
        idle_r = mk(1'b0, C_NONE, 32'h0, 3'b000, 1'b0);
        idle_a = mk(1'b0, C_NONE, 32'h0, 3'b111, 1'b0);
        @(negedge clk);

        // Head-of-line blocking on a stalled LSU, then in-order release
        tbl[0] = '{mk(1'b1, C_LSU,  32'h10, 3'b101, 1'b0), {1'b0, BYP, 1'b0}, 1'b0, 0, 0, 32'h10};
        tbl[1] = '{mk(1'b1, C_ALU,  32'h14, 3'b101, 1'b0), 3'b010, 1'b0, 1, 0, 32'h10};
        tbl[2] = '{mk(1'b1, C_MD,   32'h18, 3'b101, 1'b0), 3'b010, 1'b0, 2, 1, 32'h10};
        tbl[3] = '{mk(1'b0, C_NONE, 32'h0,  3'b101, 1'b0), 3'b010, 1'b0, 3, 2, 32'h10};
        tbl[4] = '{mk(1'b0, C_NONE, 32'h0,  3'b101, 1'b0), 3'b010, 1'b0, 3, 3, 32'h10};
        tbl[5] = '{mk(1'b0, C_NONE, 32'h0,  3'b111, 1'b0), 3'b010, 1'b0, 3, 4, 32'h10};
        tbl[6] = '{mk(1'b0, C_NONE, 32'h0,  3'b111, 1'b0), 3'b100, 1'b0, 2, 4, 32'h14};
        tbl[7] = '{mk(1'b0, C_NONE, 32'h0,  3'b111, 1'b0), 3'b001, 1'b0, 1, 4, 32'h18};
        tbl[8] = '{mk(1'b0, C_NONE, 32'h0,  3'b111, 1'b0), 3'b000, 1'b0, 0, 4, 32'h0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive_check(tbl[i].in);
            chk("tbl_valids", 32'({dq.alu_valid_o, dq.lsu_valid_o, dq.muldiv_valid_o}), 32'(tbl[i].ev));
            chk("tbl_illegal", 32'(dq.illegal_o),   32'(tbl[i].eill));
            chk("tbl_count",   32'(dq.count_o),     32'(tbl[i].ecnt));
            chk("tbl_stall",   32'(dq.stall_cnt_o), 32'(tbl[i].estall));
            if (tbl[i].ev != 3'b000) chk("tbl_pc", dq.out_pc_o, tbl[i].epc);
            advance(tbl[i].in);
        end

        // Single ALU instruction: visible next cycle, drained after handshake
        do_reset();
        x = mk(1'b1, C_ALU, 32'h100, 3'b111, 1'b0);
        drive_check(x);
        chk("lat_alu_same_cycle", 32'(dq.alu_valid_o), 32'(BYP));
        advance(x);
        drive_check(idle_a);
        if (!BYP) begin
            chk("lat_alu_valid", 32'(dq.alu_valid_o), 32'd1);
            chk("lat_alu_pc",    dq.out_pc_o,         32'h100);
        end
        advance(idle_a);
        drive_check(idle_a);
        chk("lat_count_zero", 32'(dq.count_o), 32'd0);
        advance(idle_a);

        // Unclassifiable entry is dropped with a one-cycle illegal pulse
        cycle(mk(1'b1, C_NONE, 32'h200, 3'b000, 1'b0));
        drive_check(idle_r);
        chk("ill_pulse", 32'(dq.illegal_o), 32'd1);
        chk("ill_pc",    dq.out_pc_o,       32'h200);
        chk("ill_no_valid", 32'({dq.alu_valid_o, dq.lsu_valid_o, dq.muldiv_valid_o}), 32'd0);
        advance(idle_r);
        drive_check(idle_r);
        chk("ill_gone",  32'(dq.illegal_o), 32'd0);
        chk("ill_count", 32'(dq.count_o),   32'd0);
        advance(idle_r);

        // Fill to DEPTH; fifth offer held until one entry leaves
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(mk(1'b1, C_ALU, 32'h300 + 32'(4 * i), 3'b000, 1'b0));
        x5 = mk(1'b1, C_LSU, 32'h310, 3'b000, 1'b0);
        drive_check(x5);
        chk("full_ready", 32'(dq.in_ready_o), 32'd0);
        chk("full_count", 32'(dq.count_o),    32'(DEPTH));
        advance(x5);
        x = mk(1'b1, C_LSU, 32'h310, 3'b100, 1'b0);
        drive_check(x);
        chk("full_deq_ready", 32'(dq.in_ready_o), 32'd0);
        advance(x);
        drive_check(x5);
        chk("full_reopen", 32'(dq.in_ready_o), 32'd1);
        chk("full_after",  32'(dq.count_o),    32'(DEPTH - 1));
        advance(x5);
        for (int i = 0; i < 2 * DEPTH; i++) cycle(idle_a);

        // Flush with a same-cycle enqueue attempt
        do_reset();
        for (int i = 0; i < 3; i++) cycle(mk(1'b1, C_LSU, 32'h400 + 32'(4 * i), 3'b000, 1'b0));
        cycle(mk(1'b1, C_MD, 32'h40C, 3'b000, 1'b1));
        drive_check(idle_a);
        chk("flush_count",  32'(dq.count_o), 32'd0);
        chk("flush_valids", 32'({dq.alu_valid_o, dq.lsu_valid_o, dq.muldiv_valid_o}), 32'd0);
        advance(idle_a);
        cycle(idle_a);

        // Stall counter saturation, unaffected by flush
        do_reset();
        cycle(mk(1'b1, C_LSU, 32'h500, 3'b000, 1'b0));
        for (int i = 0; i < STALL_MAX + 8; i++) cycle(idle_r);
        chk("stall_sat", 32'(dq.stall_cnt_o), 32'(STALL_MAX));
        cycle(mk(1'b0, C_NONE, 32'h0, 3'b000, 1'b1));
        chk("stall_keep_flush", 32'(dq.stall_cnt_o), 32'(STALL_MAX));
        cycle(idle_a);

        // Randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            x = mk($urandom_range(0, 3) != 0, rnd_cls(), $urandom(),
                   {1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 2) != 0)},
                   $urandom_range(0, 39) == 0);
            x.inst = $urandom();
            cycle(x);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
